deserializer_out: RTL and testbench
===================================

Name: deserializer_out

Overview:
Receive-side counterpart of the serializer_in/tx_serial pair. Consumes the 1-bit serial stream of 9-bit words {k, byte[7:0]}.
- Hunts for comma alignment ({1, 8'h3C}) and holds word lock.
- Reassembles frames of the form comma, d0, d1, d2 into one parallel word.
- Flags framing errors.
Sits directly downstream of the serial link, feeding the parallel-side consumer.

Parameters:
- COMMA, 8'h3C: K-code byte marking frame boundary / idle fill.
- DATA_BYTES, 3: data bytes per frame.
- MAX_ERR, 2: consecutive framing errors that drop lock (range 1..7).

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset. Asynchronous assert, active-low; applied to all state.
- bit_i, input, 1: serial data bit.
- bit_valid_i, input, 1: bit_i is sampled only when high.
- data_o, output, 8*DATA_BYTES: last complete frame. d0 in [7:0], d1 in [15:8], d2 in [23:16].
- valid_o, output, 1: one-cycle pulse when data_o updates.
- locked_o, output, 1: word alignment held.
- err_o, output, 1: one-cycle pulse per framing error.

Behaviour:
- Reset values: data_o=0, valid_o=0, locked_o=0, err_o=0. Internally: state=ST_HUNT, 9-bit shift reg sr=0, bit_cnt=0, idx=0, expect_comma=0, err_run=0.
- Wire format is fixed: 9-bit words, MSB (k flag) first. The upstream block sends commas when idle.
- Shifting: on every clk_i edge with bit_valid_i=1, sr <= {sr[7:0], bit_i}. Call the post-shift value sr_n. With bit_valid_i=0, all state holds.
- valid_o and err_o are registered pulses: high exactly one cycle, then 0, regardless of bit_valid_i.
- ST_HUNT:
  - locked_o=0. Each valid bit, test sr_n == {1'b1, COMMA}.
  - On match, same edge: go to ST_LOCKED, locked_o<=1, bit_cnt<=0, idx<=0, expect_comma<=0, err_run<=0.
  - Data words are not captured while hunting.
- ST_LOCKED:
  - bit_cnt counts valid bits 0..8.
  - On the valid bit with bit_cnt==8: bit_cnt<=0 and word w=sr_n is evaluated on that edge.
- Word evaluation, in priority order:
  1. w=={1,COMMA} and idx==0: accepted (idle or frame start). expect_comma<=0, err_run<=0.
  2. w=={1,COMMA} and idx!=0: truncated frame, error.
  3. w[8]==1, other byte: illegal K-code, error.
  4. w[8]==0 and expect_comma==1: missing comma, error.
  5. w[8]==0, otherwise: accepted.
     - Store byte at slot idx. err_run<=0.
     - If idx==DATA_BYTES-1: data_o <= {w[7:0], stored bytes}, valid_o<=1, idx<=0, expect_comma<=1.
     - Else idx<=idx+1.
- Error handling:
  - err_o<=1, idx<=0, expect_comma<=1, data_o unchanged.
  - If err_run+1==MAX_ERR: state<=ST_HUNT, locked_o<=0, err_run<=0. Else err_run<=err_run+1.
- Latency: valid_o goes high in the cycle after the edge that samples the 9th bit of the last data byte. data_o holds until the next complete frame.
- Back-to-back frames without an intervening comma are errors. A comma must separate frames; repeated commas are legal indefinitely.
- First frame after lock: data may follow the locking comma directly.
- Reset mid-operation:
  - Outputs go to reset values immediately, asynchronously.
  - Partial words and bytes are discarded.
  - After release, the block is in ST_HUNT and requires a fresh comma.
- Lock is never taken from a partial window: a match needs 9 valid bits in sr_n, which sr's reset value of 0 guarantees.

Test Plan:
1. Stream comma×3, then comma, 8'h11, 8'h22, 8'h33, comma -> locked_o rises after the 9th bit of the first comma. Exactly one valid_o pulse with data_o=24'h332211, one cycle after the last bit of 8'h33. err_o stays 0.
2. Prefix 5 junk bits 1,0,1,1,0 before the commas -> no lock during the junk; lock aligns to the comma; subsequent frame 8'hA1, 8'hB2, 8'hC3 gives data_o=24'hC3B2A1.
3. After lock: comma, 8'hAA, comma -> one err_o pulse, locked_o stays 1, no valid_o. Then 8'h01, 8'h02, 8'h03 gives err_o (expect_comma set). Lock drops here, since this is the 2nd consecutive error with MAX_ERR=2. Relock on the next comma; frame 8'h01, 8'h02, 8'h03 gives data_o=24'h030201.
4. After lock send K-word {1, 8'hBC} twice -> two err_o pulses; locked_o falls on the second edge; later data words are ignored until a comma.
5. Test 1 stimulus with bit_valid_i toggling 1,0,1,0 -> identical data_o. valid_o is still a single-cycle pulse. All state holds during bit_valid_i=0 cycles.
6. Assert rst_ni low mid-d1 of a frame -> all outputs 0 immediately. After release, the remaining bits of that frame produce no valid_o. The next comma plus frame 8'h10, 8'h20, 8'h30 gives data_o=24'h302010.

Source files
------------

// File: rtl/deserializer_out.sv
// Serial-to-parallel receiver: hunts for the 9-bit comma, holds word lock and
// reassembles comma-delimited frames of DATA_BYTES data bytes.
//   state     | meaning
//   ST_HUNT   | sliding a 9-bit window over every valid bit, waiting for a comma
//   ST_LOCKED | word-aligned; every 9th valid bit completes a word for evaluation
module deserializer_out #(
    parameter logic [7:0] COMMA      = 8'h3C,
    parameter int         DATA_BYTES = 3,
    parameter int         MAX_ERR    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    bit_i,
    input  logic                    bit_valid_i,
    output logic [8*DATA_BYTES-1:0] data_o,
    output logic                    valid_o,
    output logic                    locked_o,
    output logic                    err_o
);

    localparam int         IDX_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [8:0] K_COMMA = {1'b1, COMMA};

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    state_t                  r_state, w_state_n;
    logic [8:0]              r_sr, w_sr_n;
    logic [3:0]              r_bit_cnt, w_bit_cnt_n;
    logic [IDX_W-1:0]        r_idx, w_idx_n;
    logic                    r_expect_comma, w_expect_comma_n;
    logic [2:0]              r_err_run, w_err_run_n;
    logic [8*DATA_BYTES-1:0] r_store, w_store_n;
    logic [8*DATA_BYTES-1:0] r_data, w_data_n;
    logic                    r_valid, w_valid_n;
    logic                    r_err, w_err_n;
    logic                    w_word_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_HUNT;
            r_sr           <= '0;
            r_bit_cnt      <= '0;
            r_idx          <= '0;
            r_expect_comma <= 1'b0;
            r_err_run      <= '0;
            r_store        <= '0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_sr           <= w_sr_n;
            r_bit_cnt      <= w_bit_cnt_n;
            r_idx          <= w_idx_n;
            r_expect_comma <= w_expect_comma_n;
            r_err_run      <= w_err_run_n;
            r_store        <= w_store_n;
            r_data         <= w_data_n;
            r_valid        <= w_valid_n;
            r_err          <= w_err_n;
        end
    end

    always_comb begin
        w_state_n        = r_state;
        w_sr_n           = r_sr;
        w_bit_cnt_n      = r_bit_cnt;
        w_idx_n          = r_idx;
        w_expect_comma_n = r_expect_comma;
        w_err_run_n      = r_err_run;
        w_store_n        = r_store;
        w_data_n         = r_data;
        w_valid_n        = 1'b0;
        w_err_n          = 1'b0;
        w_word_err       = 1'b0;

        if (bit_valid_i) begin
            w_sr_n = {r_sr[7:0], bit_i};
            case (r_state)
                ST_HUNT: begin
                    if (w_sr_n == K_COMMA) begin
                        w_state_n        = ST_LOCKED;
                        w_bit_cnt_n      = '0;
                        w_idx_n          = '0;
                        w_expect_comma_n = 1'b0;
                        w_err_run_n      = '0;
                    end
                end
                ST_LOCKED: begin
                    if (r_bit_cnt == 4'd8) begin
                        w_bit_cnt_n = '0;
                        if (w_sr_n == K_COMMA) begin
                            if (r_idx == '0) begin
                                w_expect_comma_n = 1'b0;
                                w_err_run_n      = '0;
                            end else begin
                                w_word_err = 1'b1;
                            end
                        end else if (w_sr_n[8] || r_expect_comma) begin
                            w_word_err = 1'b1;
                        end else begin
                            w_store_n[int'(r_idx)*8 +: 8] = w_sr_n[7:0];
                            w_err_run_n = '0;
                            if (r_idx == IDX_W'(DATA_BYTES - 1)) begin
                                w_data_n         = w_store_n;
                                w_valid_n        = 1'b1;
                                w_idx_n          = '0;
                                w_expect_comma_n = 1'b1;
                            end else begin
                                w_idx_n = r_idx + 1'b1;
                            end
                        end

                        // Any framing error restarts the frame and demands a comma next
                        if (w_word_err) begin
                            w_err_n          = 1'b1;
                            w_idx_n          = '0;
                            w_expect_comma_n = 1'b1;
                            if (int'(r_err_run) + 1 == MAX_ERR) begin
                                w_state_n   = ST_HUNT;
                                w_err_run_n = '0;
                            end else begin
                                w_err_run_n = r_err_run + 3'd1;
                            end
                        end
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + 4'd1;
                    end
                end
                default: w_state_n = ST_HUNT;
            endcase
        end
    end

    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign err_o    = r_err;
    assign locked_o = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_deserializer_out.sv
// Self-checking bench for deserializer_out: word-level stimulus, random gaps,
// and a queue-based behavioural receiver model compared every cycle.
module tb_deserializer_out;

    localparam int         MAXE = 2;
    localparam logic [8:0] KC   = 9'h13C;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bit_i = 1'b0;
    logic        bit_valid_i = 1'b0;
    logic [23:0] data_o;
    logic        valid_o, locked_o, err_o;

    deserializer_out dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .locked_o    (locked_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_win;
    bit          m_locked;
    int          m_nbits;
    logic [7:0]  m_frame[$];
    bit          m_need_comma;
    int          m_errs;
    logic [23:0] m_data;
    bit          m_valid, m_err;

    int    mm_cnt, obs_valid, obs_err, ex_valid, ex_err, cyc;
    string mm_msg;

    task automatic model_reset();
        m_win = 0; m_locked = 0; m_nbits = 0; m_frame.delete();
        m_need_comma = 0; m_errs = 0; m_data = '0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_bit(input bit b);
        bit is_comma, bad;
        m_win = ((m_win << 1) | int'(b)) & 511;
        if (!m_locked) begin
            if (m_win == int'(KC)) begin
                m_locked = 1; m_nbits = 0; m_frame.delete(); m_need_comma = 0; m_errs = 0;
            end
            return;
        end
        m_nbits++;
        if (m_nbits < 9) return;
        m_nbits = 0;
        is_comma = (m_win == int'(KC));
        if (is_comma) bad = (m_frame.size() != 0);
        else          bad = (m_win >= 256) || m_need_comma;
        if (bad) begin
            m_err = 1; m_frame.delete(); m_need_comma = 1; m_errs++;
            if (m_errs == MAXE) begin m_locked = 0; m_errs = 0; end
        end else if (is_comma) begin
            m_need_comma = 0; m_errs = 0;
        end else begin
            m_frame.push_back(8'(m_win));
            m_errs = 0;
            if (m_frame.size() == 3) begin
                m_data = {m_frame[2], m_frame[1], m_frame[0]};
                m_valid = 1; m_frame.delete(); m_need_comma = 1;
            end
        end
    endtask

    task automatic begin_phase();
        mm_cnt = 0; obs_valid = 0; obs_err = 0; ex_valid = 0; ex_err = 0; mm_msg = "";
    endtask

    task automatic step(input bit b, input bit v);
        bit_i = b; bit_valid_i = v;
        @(posedge clk_i);
        m_valid = 0; m_err = 0;
        if (v) model_bit(b);
        #1;
        cyc++;
        if (valid_o === 1'b1) obs_valid++;
        if (err_o === 1'b1) obs_err++;
        if (m_valid) ex_valid++;
        if (m_err) ex_err++;
        if (valid_o !== m_valid || err_o !== m_err || locked_o !== m_locked || data_o !== m_data) begin
            if (mm_cnt == 0)
                mm_msg = $sformatf("cycle %0d got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h",
                                   cyc, valid_o, err_o, locked_o, data_o, m_valid, m_err, m_locked, m_data);
            mm_cnt++;
        end
    endtask

    task automatic send_word(input bit k, input logic [7:0] d, input int gap_mode);
        logic [8:0] w;
        int g;
        w = {k, d};
        for (int i = 8; i >= 0; i--) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
            repeat (g) step(1'($urandom_range(0, 1)), 1'b0);
            step(w[i], 1'b1);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int gm);
        send_word(1'b1, 8'h3C, gm);
        send_word(1'b0, a, gm);
        send_word(1'b0, b, gm);
        send_word(1'b0, c, gm);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0; bit_valid_i = 1'b0; model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic check_model(input string name);
        checks++;
        if (mm_cnt != 0) begin
            errors++;
            $display("FAIL %s_model %0d cycle mismatches, first: %s", name, mm_cnt, mm_msg);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; model_reset();
        #3;
        checks++;
        if ({data_o, valid_o, locked_o, err_o} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got d=%h v=%b l=%b e=%b want all 0", data_o, valid_o, locked_o, err_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_lock_frame(input int gm);
        logic [8:0] w;
        begin_phase();
        w = KC;
        for (int i = 8; i >= 1; i--) step(w[i], 1'b1);
        checks++;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL t1_nolock_8bits got %b want 0", locked_o); end
        step(w[0], 1'b1);
        checks++;
        if (locked_o !== 1'b1) begin errors++; $display("FAIL t1_lock_9th got %b want 1", locked_o); end
        send_word(1'b1, 8'h3C, gm);
        send_word(1'b1, 8'h3C, gm);
        send_word(1'b1, 8'h3C, gm);
        send_word(1'b0, 8'h11, gm);
        send_word(1'b0, 8'h22, gm);
        send_word(1'b0, 8'h33, gm);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 24'h332211) begin
            errors++;
            $display("FAIL t1_valid_timing got v=%b d=%h want v=1 d=332211", valid_o, data_o);
        end
        send_word(1'b1, 8'h3C, gm);
        checks++;
        if (obs_valid != 1 || obs_err != 0) begin
            errors++;
            $display("FAIL t1_pulse_counts got valid=%0d err=%0d want valid=1 err=0", obs_valid, obs_err);
        end
        checks++;
        if (data_o !== 24'h332211) begin errors++; $display("FAIL t1_data_hold got %h want 332211", data_o); end
        check_model(gm == 0 ? "t1" : "t5");
    endtask

    task automatic test_junk_align();
        apply_reset();
        begin_phase();
        step(1, 1); step(0, 1); step(1, 1); step(1, 1); step(0, 1);
        checks++;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL t2_junk_nolock got %b want 0", locked_o); end
        repeat (3) send_word(1'b1, 8'h3C, 0);
        send_frame(8'hA1, 8'hB2, 8'hC3, 0);
        send_word(1'b1, 8'h3C, 0);
        checks++;
        if (data_o !== 24'hC3B2A1 || obs_valid != 1) begin
            errors++;
            $display("FAIL t2_data got d=%h valid=%0d want d=c3b2a1 valid=1", data_o, obs_valid);
        end
        check_model("t2");
    endtask

    task automatic test_framing_errors();
        apply_reset();
        begin_phase();
        send_word(1'b1, 8'h3C, 0);
        send_word(1'b1, 8'h3C, 0);
        send_word(1'b0, 8'hAA, 0);
        send_word(1'b1, 8'h3C, 0);
        checks++;
        if (obs_err != 1 || locked_o !== 1'b1 || obs_valid != 0) begin
            errors++;
            $display("FAIL t3_truncated got err=%0d lock=%b valid=%0d want err=1 lock=1 valid=0", obs_err, locked_o, obs_valid);
        end
        send_word(1'b0, 8'h01, 0);
        send_word(1'b0, 8'h02, 0);
        send_word(1'b0, 8'h03, 0);
        checks++;
        if (obs_err != 2 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL t3_missing_comma got err=%0d lock=%b want err=2 lock=0", obs_err, locked_o);
        end
        send_frame(8'h01, 8'h02, 8'h03, 0);
        send_word(1'b1, 8'h3C, 0);
        checks++;
        if (data_o !== 24'h030201 || obs_valid != 1) begin
            errors++;
            $display("FAIL t3_relock_data got d=%h valid=%0d want d=030201 valid=1", data_o, obs_valid);
        end
        check_model("t3");
    endtask

    task automatic test_illegal_k();
        apply_reset();
        begin_phase();
        send_word(1'b1, 8'h3C, 0);
        send_word(1'b1, 8'hBC, 0);
        checks++;
        if (obs_err != 1 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL t4_first_k got err=%0d lock=%b want err=1 lock=1", obs_err, locked_o);
        end
        send_word(1'b1, 8'hBC, 0);
        checks++;
        if (err_o !== 1'b1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_second_k got err=%b lock=%b want err=1 lock=0", err_o, locked_o);
        end
        send_word(1'b0, 8'h55, 0);
        send_word(1'b0, 8'h66, 0);
        send_word(1'b0, 8'h77, 0);
        checks++;
        if (obs_err != 2 || obs_valid != 0 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_ignored got err=%0d valid=%0d lock=%b want err=2 valid=0 lock=0", obs_err, obs_valid, locked_o);
        end
        send_frame(8'h44, 8'h55, 8'h66, 0);
        checks++;
        if (data_o !== 24'h665544) begin errors++; $display("FAIL t4_relock_data got %h want 665544", data_o); end
        check_model("t4");
    endtask

    task automatic test_reset_mid();
        logic [8:0] w;
        apply_reset();
        begin_phase();
        send_frame(8'h77, 8'h88, 8'h99, 0);
        send_word(1'b1, 8'h10, 0);
        send_word(1'b1, 8'h3C, 0);
        send_word(1'b0, 8'h10, 0);
        w = {1'b0, 8'h20};
        for (int i = 8; i >= 5; i--) step(w[i], 1'b1);
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({data_o, valid_o, locked_o, err_o} !== 27'd0) begin
            errors++;
            $display("FAIL t6_async_reset got d=%h v=%b l=%b e=%b want all 0", data_o, valid_o, locked_o, err_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 4; i >= 0; i--) step(w[i], 1'b1);
        send_word(1'b0, 8'h30, 0);
        checks++;
        if (obs_valid != 1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL t6_discard got valid=%0d lock=%b want valid=1 lock=0", obs_valid, locked_o);
        end
        send_frame(8'h10, 8'h20, 8'h30, 0);
        send_word(1'b1, 8'h3C, 0);
        checks++;
        if (data_o !== 24'h302010 || obs_valid != 2) begin
            errors++;
            $display("FAIL t6_after_reset got d=%h valid=%0d want d=302010 valid=2", data_o, obs_valid);
        end
        check_model("t6");
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        apply_reset();
        begin_phase();
        send_word(1'b1, 8'h3C, 2);
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                send_frame(8'($urandom), 8'($urandom), 8'($urandom), 2);
            end else if (r < 70) begin
                send_word(1'b1, 8'h3C, 2);
            end else if (r < 80) begin
                send_word(1'b0, 8'($urandom), 2);
            end else if (r < 88) begin
                b = 8'($urandom);
                if (b == 8'h3C) b = 8'h3D;
                send_word(1'b1, b, 2);
            end else if (r < 95) begin
                repeat ($urandom_range(1, 4)) step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                send_word(1'b0, 8'($urandom), 2);
                send_word(1'b0, 8'($urandom), 2);
                send_word(1'b0, 8'($urandom), 2);
            end
        end
        checks++;
        if (obs_valid != ex_valid || obs_err != ex_err) begin
            errors++;
            $display("FAIL rnd_counts got valid=%0d err=%0d want valid=%0d err=%0d", obs_valid, obs_err, ex_valid, ex_err);
        end
        check_model("rnd");
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_lock_frame(0);
        test_junk_align();
        test_framing_errors();
        test_illegal_k();
        apply_reset();
        test_lock_frame(1);
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
